window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Consumer side of the 3-row pixel line buffer in the Canny pipeline. Takes the three vertical taps the line buffer emits per loaded pixel and assembles a raster-ordered 3x3 neighbourhood. Emits one window per interior pixel, with centre coordinates and an end-of-frame pulse. Feeds the Sobel/gradient stage.

## Interface
- `WIDTH`, 320: pixels per line; must equal the line buffer depth.
- `HEIGHT`, 240: lines per frame.
- `PW`, 3: pixel width in bits.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ld`  in  1  the same pixel strobe that drives the line buffer.
- `tap_top`  in  PW  pixel two lines above the current pixel (oldest row).
- `tap_mid`  in  PW  pixel one line above the current pixel.
- `tap_bot`  in  PW  current pixel.
- `win`  out  9*PW  window; element (r,c) at `win[PW*(3*r+c) +: PW]`, r=0 top row, c=0 leftmost (oldest) column.
- `win_valid`  out  1  one-cycle strobe: `win`, `out_x` and `out_y` are new.
- `out_x`  out  $clog2(WIDTH)  centre column of `win`.
- `out_y`  out  $clog2(HEIGHT)  centre row of `win`.
- `frame_done`  out  1  one-cycle pulse, coincident with the last window of a frame.

## Operation
- The line buffer registers its taps one cycle after `ld`. This block registers `ld` into `tap_vld`, and every action below is qualified by `tap_vld`.
- Column shift on `tap_vld`: col2 <= col1, col1 <= col0, col0 <= {tap_top, tap_mid, tap_bot}. Column registers are never cleared except by reset.
- Raster counters x (0..WIDTH-1) and y (0..HEIGHT-1) track the pixel in `tap_bot`.
  - x increments on each `tap_vld`.
  - At x=WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0.
- FSM states:
  - PRIME: entered on reset. Stays here while y<2. Moves to STREAM on the `tap_vld` that wraps x from WIDTH-1 with y=1.
  - STREAM: returns to PRIME on the frame wrap.
- Window emit: on a `tap_vld` in STREAM with x>=2, register `win` from {col2, col1, col0} including the current taps, set out_x=x-1 and out_y=y-1, and pulse `win_valid`.
- Windows with x<2 are suppressed. This prevents stale columns from the previous line from ever appearing in an emitted window.
- `frame_done` pulses with the window at x=WIDTH-1, y=HEIGHT-1.
- Output count per frame is exactly (WIDTH-2)*(HEIGHT-2). Border pixels produce no window.
- Gaps in `ld` are arbitrary. Nothing advances without `tap_vld`, and back-to-back `ld` sustains one window per cycle.
- Reset mid-frame clears counters, FSM state, `tap_vld` and all outputs. The first `ld` after reset is pixel (0,0). The line buffer shares the same `rst`.
- `ld` asserted in the reset cycle is ignored.

## Timing
- Reset values: `win`=0, `win_valid`=0, `out_x`=0, `out_y`=0, `frame_done`=0, all columns 0, state PRIME.
- Latency: an `ld` in cycle n yields `win_valid` in cycle n+2 (n+1 taps valid, n+2 window registered).
- `win`, `out_x` and `out_y` hold their values between strobes.
- `win_valid` and `frame_done` are single-cycle and never asserted without a preceding `ld`.
- Throughput: 1 window per cycle.

## Structure
- Shared package `canny_pkg`:
  - `PIX_W` constant and default `IMG_W`/`IMG_H`.
  - `win_t` packed 3x3 type.
  - Function `win_idx(r,c)`.
- Sub-module `raster_counter` (params W, H): x/y counters with enable, a line-wrap flag and a frame-wrap flag; reusable by downstream stages.
- All other logic (FSM, column registers, output registers) sits in the top module.

## Test plan
All scenarios use WIDTH=8, HEIGHT=6, and pixel (x,y) = (x+y) mod 8 fed through the real line buffer.
- Continuous `ld`, 48 pixels -> first `win_valid` 2 cycles after `ld` #18 (0-based), with out_x=1, out_y=1, w00=0, w11=2, w22=4. Exactly 24 strobes in total, and `frame_done` coincides with out_x=6, out_y=4, w22=(7+5) mod 8=4.
- `ld` every other cycle -> same 24 windows in the same order and values. `win_valid` never appears in two consecutive cycles.
- Line-start check -> no window with out_x=0 or 7. The first window of each line has out_x=1, with w00 equal to pixel (0, out_y-1).
- Reset asserted after `ld` #30, then a fresh frame -> all outputs 0 in the cycle after reset. The next window is again (1,1) with w11=2, and no stale pixels appear.
- Two back-to-back frames, frame 2 pixel = (x+y+3) mod 8 -> frame 2's first window has w00=3 and w11=5. `frame_done` pulses once per frame and the count is 24 per frame.
- `ld` held high during reset -> no `win_valid` until 18 post-reset loads have occurred.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and defaults for the Canny pipeline stages.
package canny_pkg;

  localparam int unsigned PIX_W = 3;
  localparam int unsigned IMG_W = 320;
  localparam int unsigned IMG_H = 240;

  // Element (r,c) sits at flat index 3*r+c; r=0 is the top row, c=0 the oldest column.
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  function automatic int win_idx(int r, int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Tap input / window output bundle between the line buffer, window generator and Sobel stage.
interface window_3x3_gen_if
  import canny_pkg::*;
#(
  parameter int unsigned WIDTH  = IMG_W,
  parameter int unsigned HEIGHT = IMG_H,
  parameter int unsigned PW     = PIX_W
);
  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  logic            ld;
  logic [PW-1:0]   tap_top;
  logic [PW-1:0]   tap_mid;
  logic [PW-1:0]   tap_bot;
  logic [9*PW-1:0] win;
  logic            win_valid;
  logic [XW-1:0]   out_x;
  logic [YW-1:0]   out_y;
  logic            frame_done;

  modport master (
    output ld, tap_top, tap_mid, tap_bot,
    input  win, win_valid, out_x, out_y, frame_done
  );

  modport slave (
    input  ld, tap_top, tap_mid, tap_bot,
    output win, win_valid, out_x, out_y, frame_done
  );

endinterface

// File: rtl/raster_counter.sv
// Raster-order x/y position counter with line-wrap and frame-wrap flags.
module raster_counter
  import canny_pkg::*;
#(
  parameter int unsigned W = IMG_W,
  parameter int unsigned H = IMG_H
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  output logic [$clog2(W)-1:0] x_o,
  output logic [$clog2(H)-1:0] y_o,
  output logic                 line_wrap_o,
  output logic                 frame_wrap_o
);

  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Flags are qualified by en_i so they mark the cycle in which the wrap happens.
  always_comb begin
    line_wrap_o  = en_i && (x_q == XW'(W - 1));
    frame_wrap_o = line_wrap_o && (y_q == YW'(H - 1));
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      if (line_wrap_o) begin
        x_d = '0;
        y_d = frame_wrap_o ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/window_3x3_gen.sv
// Assembles a 3x3 neighbourhood from line-buffer taps; one window per interior pixel.
module window_3x3_gen
  import canny_pkg::*;
#(
  parameter int unsigned WIDTH  = IMG_W,
  parameter int unsigned HEIGHT = IMG_H,
  parameter int unsigned PW     = PIX_W
) (
  input  logic            clk,
  input  logic            rst,
  window_3x3_gen_if.slave io
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  localparam logic [0:0] StPrime  = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  logic                 tap_vld_q;
  logic [0:0]           state_q, state_d;
  logic [2:0][PW-1:0]   taps;
  logic [2:0][PW-1:0]   col0_q, col0_d, col1_q, col1_d;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic                 line_wrap, frame_wrap;
  logic                 emit;
  logic [9*PW-1:0]      win_new;
  logic [9*PW-1:0]      win_q, win_d;
  logic                 win_valid_q, win_valid_d;
  logic [XW-1:0]        out_x_q, out_x_d;
  logic [YW-1:0]        out_y_q, out_y_d;
  logic                 frame_done_q, frame_done_d;

  raster_counter #(
    .W (WIDTH),
    .H (HEIGHT)
  ) u_raster (
    .clk          (clk),
    .rst          (rst),
    .en_i         (tap_vld_q),
    .x_o          (x),
    .y_o          (y),
    .line_wrap_o  (line_wrap),
    .frame_wrap_o (frame_wrap)
  );

  assign taps[0] = io.tap_top;
  assign taps[1] = io.tap_mid;
  assign taps[2] = io.tap_bot;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StPrime:  if (line_wrap && (y == YW'(1))) state_d = StStream;
      StStream: if (frame_wrap) state_d = StPrime;
      default:  state_d = StPrime;
    endcase
  end

  // The oldest column of the window is col1_q: it becomes col2 on this same shift.
  always_comb begin
    win_new = '0;
    for (int r = 0; r < 3; r++) begin
      win_new[PW*win_idx(r, 0) +: PW] = col1_q[r];
      win_new[PW*win_idx(r, 1) +: PW] = col0_q[r];
      win_new[PW*win_idx(r, 2) +: PW] = taps[r];
    end
  end

  always_comb begin
    col0_d = col0_q;
    col1_d = col1_q;
    if (tap_vld_q) begin
      col1_d = col0_q;
      col0_d = taps;
    end
    // x<2 would pull columns from the previous line, so those windows are dropped.
    emit         = tap_vld_q && (state_q == StStream) && (x >= XW'(2));
    win_d        = emit ? win_new : win_q;
    out_x_d      = emit ? x - 1'b1 : out_x_q;
    out_y_d      = emit ? y - 1'b1 : out_y_q;
    win_valid_d  = emit;
    frame_done_d = emit && frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_vld_q    <= 1'b0;
      state_q      <= StPrime;
      col0_q       <= '0;
      col1_q       <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      tap_vld_q    <= io.ld;
      state_q      <= state_d;
      col0_q       <= col0_d;
      col1_q       <= col1_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign io.win        = win_q;
  assign io.win_valid  = win_valid_q;
  assign io.out_x      = out_x_q;
  assign io.out_y      = out_y_q;
  assign io.frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on an 8x6 frame fed through a behavioural line buffer.
module tb_window_3x3_gen;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned PW = 3;
  localparam int NWIN = (W - 2) * (H - 2);

  typedef struct {
    int              x;
    int              y;
    logic [9*PW-1:0] w;
    bit              fd;
    int              cyc;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pix = '0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  rec_t wins[$];
  int   ld_cycs[$];

  logic [PW-1:0] row0 [W];
  logic [PW-1:0] row1 [W];
  int            lb_x = 0;

  window_3x3_gen_if #(.WIDTH(W), .HEIGHT(H), .PW(PW)) bus ();

  window_3x3_gen #(.WIDTH(W), .HEIGHT(H), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line buffer: taps registered one cycle after ld, top = two lines up.
  always @(posedge clk) begin
    if (rst) begin
      bus.tap_top <= '0;
      bus.tap_mid <= '0;
      bus.tap_bot <= '0;
      lb_x        <= 0;
    end else if (bus.ld) begin
      bus.tap_top <= row0[lb_x];
      bus.tap_mid <= row1[lb_x];
      bus.tap_bot <= pix;
      row0[lb_x]  <= row1[lb_x];
      row1[lb_x]  <= pix;
      lb_x        <= (lb_x == W - 1) ? 0 : lb_x + 1;
    end
  end

  always @(negedge clk) begin
    if (bus.win_valid) begin
      wins.push_back('{x: int'(bus.out_x), y: int'(bus.out_y), w: bus.win,
                       fd: bus.frame_done, cyc: cyc});
    end
  end

  function automatic logic [9*PW-1:0] exp_win(int cx, int cy, int off);
    logic [9*PW-1:0] e;
    e = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e[PW*(3*r+c) +: PW] = PW'((cx - 1 + c + cy - 1 + r + off) % 8);
    return e;
  endfunction

  function automatic int elem(logic [9*PW-1:0] w, int r, int c);
    return int'(w[PW*(3*r+c) +: PW]);
  endfunction

  task automatic step(input logic l, input logic [PW-1:0] v);
    bus.ld = l;
    pix    = v;
    if (l && !rst) ld_cycs.push_back(cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic feed_frame(input int gap, input int off);
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++) begin
        step(1'b1, PW'((x + y + off) % 8));
        repeat (gap) step(1'b0, '0);
      end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0);
  endtask

  task automatic clear_log();
    wins.delete();
    ld_cycs.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_checks++;
    if (bus.win !== '0) $display("FAIL reset_win got %h want 0", bus.win);
    else n_pass++;
    n_checks++;
    if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0)
      $display("FAIL reset_strobes got v=%b fd=%b want 0 0", bus.win_valid, bus.frame_done);
    else n_pass++;
    n_checks++;
    if (bus.out_x !== '0 || bus.out_y !== '0)
      $display("FAIL reset_xy got %0d,%0d want 0,0", bus.out_x, bus.out_y);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    int fd_cnt;
    int bad;
    clear_log();
    feed_frame(0, 0);
    idle(4);
    n_checks++;
    if (wins.size() != NWIN) $display("FAIL cont_count got %0d want %0d", wins.size(), NWIN);
    else n_pass++;
    if (wins.size() > 0 && ld_cycs.size() > 18) begin
      n_checks++;
      if (wins[0].cyc !== ld_cycs[18] + 2)
        $display("FAIL cont_latency got cyc %0d want %0d", wins[0].cyc, ld_cycs[18] + 2);
      else n_pass++;
      n_checks++;
      if (wins[0].x !== 1 || wins[0].y !== 1 || elem(wins[0].w, 0, 0) !== 0 ||
          elem(wins[0].w, 1, 1) !== 2 || elem(wins[0].w, 2, 2) !== 4)
        $display("FAIL cont_first got (%0d,%0d) w=%h want (1,1) w00=0 w11=2 w22=4",
                 wins[0].x, wins[0].y, wins[0].w);
      else n_pass++;
    end
    bad = 0;
    fd_cnt = 0;
    for (int i = 0; i < wins.size() && i < NWIN; i++) begin
      int cx = 1 + i % int'(W - 2);
      int cy = 1 + i / int'(W - 2);
      if (wins[i].x !== cx || wins[i].y !== cy || wins[i].w !== exp_win(cx, cy, 0)) bad++;
      if (wins[i].fd) begin
        fd_cnt++;
        n_checks++;
        if (wins[i].x !== 6 || wins[i].y !== 4 || elem(wins[i].w, 2, 2) !== 4)
          $display("FAIL cont_fd_pos got (%0d,%0d) w22=%0d want (6,4) w22=4",
                   wins[i].x, wins[i].y, elem(wins[i].w, 2, 2));
        else n_pass++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL cont_windows got %0d wrong want 0", bad);
    else n_pass++;
    n_checks++;
    if (fd_cnt != 1) $display("FAIL cont_fd_count got %0d want 1", fd_cnt);
    else n_pass++;
  endtask

  task automatic test_gapped();
    int bad;
    int adj;
    clear_log();
    feed_frame(1, 0);
    idle(4);
    n_checks++;
    if (wins.size() != NWIN) $display("FAIL gap_count got %0d want %0d", wins.size(), NWIN);
    else n_pass++;
    bad = 0;
    adj = 0;
    for (int i = 0; i < wins.size() && i < NWIN; i++) begin
      int cx = 1 + i % int'(W - 2);
      int cy = 1 + i / int'(W - 2);
      if (wins[i].x !== cx || wins[i].y !== cy || wins[i].w !== exp_win(cx, cy, 0)) bad++;
      if (i > 0 && wins[i].cyc == wins[i-1].cyc + 1) adj++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL gap_windows got %0d wrong want 0", bad);
    else n_pass++;
    n_checks++;
    if (adj != 0) $display("FAIL gap_adjacent got %0d back-to-back strobes want 0", adj);
    else n_pass++;
  endtask

  task automatic test_line_start();
    int border;
    int firsts;
    clear_log();
    feed_frame(2, 0);
    idle(4);
    border = 0;
    firsts = 0;
    foreach (wins[i]) begin
      if (wins[i].x == 0 || wins[i].x == 7) border++;
      if (wins[i].x == 1) begin
        firsts++;
        n_checks++;
        if (elem(wins[i].w, 0, 0) !== (wins[i].y - 1) % 8)
          $display("FAIL line_start_w00 y=%0d got %0d want %0d", wins[i].y,
                   elem(wins[i].w, 0, 0), (wins[i].y - 1) % 8);
        else n_pass++;
      end
    end
    n_checks++;
    if (border != 0) $display("FAIL line_border got %0d border windows want 0", border);
    else n_pass++;
    n_checks++;
    if (firsts != 4) $display("FAIL line_firsts got %0d want 4", firsts);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int bad;
    for (int i = 0; i < 31; i++) step(1'b1, PW'((i % int'(W) + i / int'(W)) % 8));
    rst = 1'b1;
    step(1'b0, '0);
    rst = 1'b0;
    n_checks++;
    if (bus.win !== '0 || bus.win_valid !== 1'b0 || bus.out_x !== '0 ||
        bus.out_y !== '0 || bus.frame_done !== 1'b0)
      $display("FAIL mid_reset_outputs got w=%h v=%b x=%0d y=%0d fd=%b want all 0",
               bus.win, bus.win_valid, bus.out_x, bus.out_y, bus.frame_done);
    else n_pass++;
    clear_log();
    feed_frame(0, 0);
    idle(4);
    n_checks++;
    if (wins.size() != NWIN) $display("FAIL mid_reset_count got %0d want %0d", wins.size(), NWIN);
    else n_pass++;
    if (wins.size() > 0) begin
      n_checks++;
      if (wins[0].x !== 1 || wins[0].y !== 1 || elem(wins[0].w, 1, 1) !== 2)
        $display("FAIL mid_reset_first got (%0d,%0d) w11=%0d want (1,1) w11=2",
                 wins[0].x, wins[0].y, elem(wins[0].w, 1, 1));
      else n_pass++;
    end
    bad = 0;
    for (int i = 0; i < wins.size() && i < NWIN; i++)
      if (wins[i].w !== exp_win(1 + i % int'(W - 2), 1 + i / int'(W - 2), 0)) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL mid_reset_windows got %0d wrong want 0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad;
    int fd_cnt;
    clear_log();
    feed_frame(0, 0);
    feed_frame(0, 3);
    idle(4);
    n_checks++;
    if (wins.size() != 2 * NWIN)
      $display("FAIL b2b_count got %0d want %0d", wins.size(), 2 * NWIN);
    else n_pass++;
    bad = 0;
    fd_cnt = 0;
    foreach (wins[i]) if (wins[i].fd) fd_cnt++;
    n_checks++;
    if (fd_cnt != 2) $display("FAIL b2b_fd_count got %0d want 2", fd_cnt);
    else n_pass++;
    if (wins.size() == 2 * NWIN) begin
      n_checks++;
      if (!wins[NWIN-1].fd || !wins[2*NWIN-1].fd)
        $display("FAIL b2b_fd_place got %b %b want 1 1", wins[NWIN-1].fd, wins[2*NWIN-1].fd);
      else n_pass++;
      n_checks++;
      if (elem(wins[NWIN].w, 0, 0) !== 3 || elem(wins[NWIN].w, 1, 1) !== 5)
        $display("FAIL b2b_f2_first got w00=%0d w11=%0d want 3 5",
                 elem(wins[NWIN].w, 0, 0), elem(wins[NWIN].w, 1, 1));
      else n_pass++;
      for (int i = 0; i < NWIN; i++)
        if (wins[NWIN+i].w !== exp_win(1 + i % int'(W - 2), 1 + i / int'(W - 2), 3)) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL b2b_f2_windows got %0d wrong want 0", bad);
      else n_pass++;
    end
  endtask

  task automatic test_ld_in_reset();
    int pre;
    clear_log();
    rst = 1'b1;
    repeat (3) step(1'b1, 3'd7);
    rst = 1'b0;
    pre = wins.size();
    n_checks++;
    if (pre != 0) $display("FAIL ld_rst_quiet got %0d strobes want 0", pre);
    else n_pass++;
    feed_frame(0, 0);
    idle(4);
    n_checks++;
    if (wins.size() != NWIN) $display("FAIL ld_rst_count got %0d want %0d", wins.size(), NWIN);
    else n_pass++;
    if (wins.size() > 0 && ld_cycs.size() > 18) begin
      n_checks++;
      if (wins[0].cyc !== ld_cycs[18] + 2 || wins[0].x !== 1 || wins[0].y !== 1 ||
          wins[0].w !== exp_win(1, 1, 0))
        $display("FAIL ld_rst_first got cyc %0d (%0d,%0d) w=%h want cyc %0d (1,1) w=%h",
                 wins[0].cyc, wins[0].x, wins[0].y, wins[0].w, ld_cycs[18] + 2,
                 exp_win(1, 1, 0));
      else n_pass++;
    end
  endtask

  initial begin
    bus.ld = 1'b0;
    #1;
    test_reset();
    test_continuous();
    test_gapped();
    test_line_start();
    test_mid_reset();
    test_back_to_back();
    test_ld_in_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
